// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 instruction-fetch stage.
package msrv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } ifetch_state_t;

endpackage

// File: rtl/msrv32_fetch_fifo.sv
// Small circular instruction buffer between the AHB data phase and decode.
module msrv32_fetch_fifo
    import msrv32_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           clear,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    output fetch_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Callers never push when full or pop when empty; the credit rule upstream guarantees it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !clear)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/msrv32_ifetch.sv
// Fetch stage: owns the fetch PC, issues pipelined AHB-lite word reads and queues results for decode.
module msrv32_ifetch
    import msrv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] pc_mux_in,
    input  logic        flush_in,
    output logic [31:0] pc_out,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_rdata_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_misaligned_out
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    ifetch_state_t state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   tag_reg, tag_next;
    logic          outstanding_reg, outstanding_next;
    logic          discard_reg, discard_next;

    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    fetch_entry_t  head, push_data;
    logic          accept, complete, mis_push, push, pop, valid;

    // An outstanding data phase reserves a FIFO slot so a returning word always has room.
    assign credit_used  = {1'b0, count} + (CW + 1)'(outstanding_reg);
    assign imem_req_out = (state_reg == S_RUN) && !flush_in && (pc_reg[1:0] == 2'b00)
                          && (credit_used < DEPTH_W);
    assign accept   = imem_req_out && imem_ready_in;
    assign complete = outstanding_reg && imem_ready_in;
    // The marker waits for any in-flight word so program order is kept.
    assign mis_push = (state_reg == S_RUN) && !flush_in && (pc_reg[1:0] != 2'b00)
                      && !outstanding_reg && ({1'b0, count} < DEPTH_W);
    assign push     = !flush_in && ((complete && !discard_reg) || mis_push);
    assign valid    = (count != '0);
    assign pop      = valid && instr_ready_in && !flush_in;

    always_comb begin
        push_data = '{instr: imem_rdata_in, pc: tag_reg, misaligned: 1'b0};
        if (mis_push)
            push_data = '{instr: NOP_INSTR, pc: pc_reg, misaligned: 1'b1};
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        tag_next         = tag_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;

        case (state_reg)
            S_BOOT:  state_next = S_RUN;
            S_RUN:   if (mis_push) state_next = S_HALT;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_BOOT;
        endcase

        if (accept) begin
            pc_next          = pc_mux_in;
            tag_next         = pc_reg;
            outstanding_next = 1'b1;
        end else if (complete) begin
            outstanding_next = 1'b0;
        end

        if (complete)
            discard_next = 1'b0;

        if (flush_in) begin
            state_next = S_RUN;
            pc_next    = pc_mux_in;
            if (outstanding_reg && !imem_ready_in)
                discard_next = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg       <= S_BOOT;
            pc_reg          <= RESET_PC;
            tag_reg         <= '0;
            outstanding_reg <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            tag_reg         <= tag_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    msrv32_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (flush_in),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign pc_out               = pc_reg;
    assign imem_addr_out        = {pc_reg[31:2], 2'b00};
    assign instr_valid_out      = valid;
    assign instr_out            = valid ? head.instr : NOP_INSTR;
    assign instr_pc_out         = valid ? head.pc : 32'h0;
    assign instr_misaligned_out = valid && head.misaligned;

endmodule

// File: tb/tb_msrv32_ifetch.sv
// Randomised bench: AHB slave + PC-unit stimulus against a queue-based fetch model.
module tb_msrv32_ifetch;

    localparam int          DEPTH = 3;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] pc_mux_in = '0;
    logic        flush_in = 1'b0;
    logic [31:0] pc_out;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in = 1'b0;
    logic [31:0] imem_rdata_in = '0;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_misaligned_out;

    msrv32_ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .pc_mux_in            (pc_mux_in),
        .flush_in             (flush_in),
        .pc_out               (pc_out),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_ready_in        (imem_ready_in),
        .imem_rdata_in        (imem_rdata_in),
        .instr_valid_out      (instr_valid_out),
        .instr_ready_in       (instr_ready_in),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
        .instr_misaligned_out (instr_misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          mis;
    } ent_t;

    // Model: 0 = boot, 1 = run, 2 = halt
    int          m_state;
    logic [31:0] m_pc, m_tag;
    bit          m_out, m_disc;
    ent_t        m_q[$];

    bit          s_pend;
    logic [31:0] s_addr;
    bit          release_pending;
    int          stall_cnt;
    int          n_cmp, n_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = RPC;
        m_tag   = '0;
        m_out   = 0;
        m_disc  = 0;
        m_q.delete();
        s_pend  = 0;
    endtask

    function automatic bit model_req();
        return (m_state == 1) && !flush_in && (m_pc[1:0] == 2'b00)
               && (m_q.size() + int'(m_out) < DEPTH);
    endfunction

    task automatic compare_outputs();
        bit req;
        req = model_req();
        check_eq("pc_out", pc_out, m_pc);
        check_eq("req", {31'b0, imem_req_out}, {31'b0, req});
        check_eq("addr", imem_addr_out, {m_pc[31:2], 2'b00});
        check_eq("valid", {31'b0, instr_valid_out}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            check_eq("instr", instr_out, m_q[0].instr);
            check_eq("instr_pc", instr_pc_out, m_q[0].pc);
            check_eq("mis", {31'b0, instr_misaligned_out}, {31'b0, m_q[0].mis});
        end else begin
            check_eq("instr_empty", instr_out, NOP);
            check_eq("instr_pc_empty", instr_pc_out, 32'h0);
            check_eq("mis_empty", {31'b0, instr_misaligned_out}, 32'h0);
        end
    endtask

    task automatic model_step();
        bit req, was_out;
        int sz;
        req     = model_req();
        was_out = m_out;
        sz      = m_q.size();
        if (flush_in) begin
            m_q.delete();
            if (m_out && !imem_ready_in) m_disc = 1;
            else if (m_out) begin m_out = 0; m_disc = 0; end
            m_pc    = pc_mux_in;
            m_state = 1;
            $display("flush -> %h", pc_mux_in);
        end else begin
            if (sz > 0 && instr_ready_in) begin
                $display("pop pc=%h instr=%h mis=%0d", m_q[0].pc, m_q[0].instr, m_q[0].mis);
                void'(m_q.pop_front());
            end
            if (m_out && imem_ready_in) begin
                if (!m_disc) m_q.push_back('{instr: mem_word(m_tag), pc: m_tag, mis: 0});
                m_disc = 0;
                m_out  = 0;
            end else if (m_state == 1 && m_pc[1:0] != 2'b00 && !was_out && sz < DEPTH) begin
                m_q.push_back('{instr: NOP, pc: m_pc, mis: 1});
                m_state = 2;
            end
            if (req && imem_ready_in) begin
                m_out = 1;
                m_tag = m_pc;
                m_pc  = pc_mux_in;
            end
            if (m_state == 0) m_state = 1;
        end
    endtask

    task automatic drive_inputs();
        logic [31:0] tgt;
        imem_ready_in = ($urandom_range(0, 4) != 0);
        if (stall_cnt > 0) begin
            instr_ready_in = 1'b0;
            stall_cnt--;
        end else if ($urandom_range(0, 49) == 0) begin
            instr_ready_in = 1'b0;
            stall_cnt = 5;
        end else begin
            instr_ready_in = ($urandom_range(0, 3) != 0);
        end
        flush_in = (m_state == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 5))
            0:       tgt = 32'h0000_0100;
            1:       tgt = 32'h0000_0200;
            2:       tgt = 32'h0000_0102;
            3:       tgt = {16'h0, $urandom_range(0, 16'hFFFF)} | 32'h1;
            default: tgt = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
        endcase
        if (flush_in)                          pc_mux_in = tgt;
        else if ($urandom_range(0, 59) == 0)   pc_mux_in = m_pc + 32'd6;
        else                                   pc_mux_in = m_pc + 32'd4;
        imem_rdata_in = s_pend ? mem_word(s_addr) : $urandom;
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
        if (release_pending) begin
            rst_in = 1'b1;
            release_pending = 0;
        end
        drive_inputs();
        @(negedge clk_in);
        compare_outputs();
        if (rst_in) begin
            model_step();
            if (imem_ready_in) begin
                s_pend = imem_req_out;
                s_addr = imem_addr_out;
            end
        end else begin
            s_pend = 0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        stall_cnt = 0;
        model_reset();
        #1;
        compare_outputs();
        repeat (2) cycle();
        release_pending = 1;
        repeat (1500) cycle();
        // Asynchronous reset in the middle of traffic, checked before the next edge.
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        release_pending = 1;
        repeat (1500) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
